// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller: NS/EW green-yellow-all-red sequencing with
// latched pedestrian early-green termination and a night-mode yellow flash.
module traffic_light_ctrl #(
   parameter int CNT_W       = 8,
   parameter int GREEN_T     = 27,
   parameter int YELLOW_T    = 3,
   parameter int ALLRED_T    = 2,
   parameter int MIN_GREEN_T = 8,
   parameter int FLASH_T     = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       ped_req,
   input  logic       flash_en,
   output logic       ns_green,
   output logic       ns_yellow,
   output logic       ns_red,
   output logic       ew_green,
   output logic       ew_yellow,
   output logic       ew_red,
   output logic       ped_ack,
   output logic [2:0] phase
);

   // state | meaning
   // NS_G  | NS green, EW red
   // NS_Y  | NS yellow, EW red
   // AR1   | all red before EW green (or FLASH)
   // EW_G  | EW green, NS red
   // EW_Y  | EW yellow, NS red
   // AR2   | all red before NS green (or FLASH); reset state
   // FLASH | night mode, both yellows blink, everything else dark
   typedef enum logic [2:0] {
      NS_G  = 3'd0,
      NS_Y  = 3'd1,
      AR1   = 3'd2,
      EW_G  = 3'd3,
      EW_Y  = 3'd4,
      AR2   = 3'd5,
      FLASH = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] GREEN_C  = CNT_W'(GREEN_T);
   localparam logic [CNT_W-1:0] YELLOW_C = CNT_W'(YELLOW_T);
   localparam logic [CNT_W-1:0] ALLRED_C = CNT_W'(ALLRED_T);
   localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_GREEN_T);
   localparam logic [CNT_W-1:0] FLASH_C  = CNT_W'(FLASH_T);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             blink_q, blink_d;
   logic             ack_q, ack_d;
   logic [5:0]       lamps_q, lamps_d;   // {ns g,y,r, ew g,y,r}
   logic             want;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      pend_d  = pend_q | (ped_req && (state_q != FLASH));
      blink_d = blink_q;
      ack_d   = 1'b0;
      // a request arriving in the very cycle green ends is served by that ack
      want    = pend_q | ped_req;
      unique case (state_q)
         NS_G, EW_G: begin
            if ((cnt_q == GREEN_C) || (want && (cnt_q >= MIN_C))) begin
               state_d = (state_q == NS_G) ? NS_Y : EW_Y;
               cnt_d   = '0;
               pend_d  = 1'b0;
               ack_d   = want;
            end
         end
         NS_Y, EW_Y: begin
            if (cnt_q == YELLOW_C) begin
               state_d = (state_q == NS_Y) ? AR1 : AR2;
               cnt_d   = '0;
            end
         end
         AR1, AR2: begin
            if (cnt_q == ALLRED_C) begin
               cnt_d = '0;
               if (flash_en) begin
                  state_d = FLASH;
                  pend_d  = 1'b0;
                  blink_d = 1'b1;
               end else begin
                  state_d = (state_q == AR1) ? EW_G : NS_G;
               end
            end
         end
         FLASH: begin
            if (!flash_en) begin
               state_d = AR2;
               cnt_d   = '0;
            end else if (cnt_q == FLASH_C) begin
               blink_d = ~blink_q;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = AR2;
            cnt_d   = '0;
         end
      endcase

      unique case (state_d)
         NS_G:    lamps_d = 6'b100_001;
         NS_Y:    lamps_d = 6'b010_001;
         EW_G:    lamps_d = 6'b001_100;
         EW_Y:    lamps_d = 6'b001_010;
         FLASH:   lamps_d = {1'b0, blink_d, 1'b0, 1'b0, blink_d, 1'b0};
         default: lamps_d = 6'b001_001;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= AR2;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         blink_q <= 1'b0;
         ack_q   <= 1'b0;
         lamps_q <= 6'b001_001;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         blink_q <= blink_d;
         ack_q   <= ack_d;
         lamps_q <= lamps_d;
      end
   end

   assign {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red} = lamps_q;
   assign ped_ack = ack_q;
   assign phase   = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench: two controllers (default and short-timing parameters) share
// stimulus; a per-cycle reference model queues expected lamps/phase/ack.
module tb_traffic_light_ctrl;

   logic clk = 1'b0;
   logic rstn, ped_req, flash_en;
   always #5 clk = ~clk;

   wire [2:0] ph0, ph1;
   wire [5:0] lmp0, lmp1;
   wire       ack0, ack1;

   traffic_light_ctrl u_dut0 (
      .clk(clk), .rstn(rstn), .ped_req(ped_req), .flash_en(flash_en),
      .ns_green(lmp0[5]), .ns_yellow(lmp0[4]), .ns_red(lmp0[3]),
      .ew_green(lmp0[2]), .ew_yellow(lmp0[1]), .ew_red(lmp0[0]),
      .ped_ack(ack0), .phase(ph0));

   traffic_light_ctrl #(.CNT_W(4), .GREEN_T(10), .YELLOW_T(1)) u_dut1 (
      .clk(clk), .rstn(rstn), .ped_req(ped_req), .flash_en(flash_en),
      .ns_green(lmp1[5]), .ns_yellow(lmp1[4]), .ns_red(lmp1[3]),
      .ew_green(lmp1[2]), .ew_yellow(lmp1[1]), .ew_red(lmp1[0]),
      .ped_ack(ack1), .phase(ph1));

   int n_vec = 0;
   int n_miss = 0;

   logic [9:0] sbq0[$];
   logic [9:0] sbq1[$];

   int   m_p[2], m_t[2];
   logic m_pend[2], m_blink[2], m_ack[2];

   function automatic logic [5:0] lamps_of(input int p, input logic b);
      case (p)
         0:       return 6'b100_001;
         1:       return 6'b010_001;
         3:       return 6'b001_100;
         4:       return 6'b001_010;
         6:       return {1'b0, b, 1'b0, 1'b0, b, 1'b0};
         default: return 6'b001_001;
      endcase
   endfunction

   // Phase lengths in cycles minus one, per instance.
   task automatic model_step(input int d);
      int g, y, a, mn, fl;
      logic eff;
      logic [9:0] e;
      g = (d == 0) ? 27 : 10;
      y = (d == 0) ? 3 : 1;
      a = 2; mn = 8; fl = 4;
      m_ack[d] = 1'b0;
      if (!rstn) begin
         m_p[d] = 5; m_t[d] = 0; m_pend[d] = 1'b0; m_blink[d] = 1'b0;
      end else if (m_p[d] == 0 || m_p[d] == 3) begin
         eff = m_pend[d] | ped_req;
         if (m_t[d] == g || (eff && m_t[d] >= mn)) begin
            m_ack[d] = eff; m_pend[d] = 1'b0; m_p[d] = m_p[d] + 1; m_t[d] = 0;
         end else begin
            m_pend[d] = eff; m_t[d]++;
         end
      end else if (m_p[d] == 1 || m_p[d] == 4) begin
         m_pend[d] = m_pend[d] | ped_req;
         if (m_t[d] == y) begin m_p[d] = m_p[d] + 1; m_t[d] = 0; end
         else m_t[d]++;
      end else if (m_p[d] == 2 || m_p[d] == 5) begin
         m_pend[d] = m_pend[d] | ped_req;
         if (m_t[d] == a) begin
            m_t[d] = 0;
            if (flash_en) begin
               m_p[d] = 6; m_pend[d] = 1'b0; m_blink[d] = 1'b1;
            end else begin
               m_p[d] = (m_p[d] == 2) ? 3 : 0;
            end
         end else m_t[d]++;
      end else begin
         if (!flash_en) begin m_p[d] = 5; m_t[d] = 0; end
         else if (m_t[d] == fl) begin m_blink[d] = ~m_blink[d]; m_t[d] = 0; end
         else m_t[d]++;
      end
      e = {3'(m_p[d]), lamps_of(m_p[d], m_blink[d]), m_ack[d]};
      if (d == 0) sbq0.push_back(e);
      else        sbq1.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      model_step(0);
      model_step(1);
   end

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s t=%0t got phase=%0d lamps=%b ack=%b, want phase=%0d lamps=%b ack=%b",
                  name, $time, act[9:7], act[6:1], act[0], exp[9:7], exp[6:1], exp[0]);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (sbq0.size() > 0) check("dut0_cycle", {ph0, lmp0, ack0}, sbq0.pop_front());
      if (sbq1.size() > 0) check("dut1_cycle", {ph1, lmp1, ack1}, sbq1.pop_front());
   end

   task automatic chk_reset();
      check("dut0_reset", {ph0, lmp0, ack0}, {3'd5, 6'b001_001, 1'b0});
      check("dut1_reset", {ph1, lmp1, ack1}, {3'd5, 6'b001_001, 1'b0});
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_enter(input logic [2:0] p);
      int n = 0;
      while (ph0 == p && n < 2000) begin tick(); n++; end
      while (ph0 != p && n < 2000) begin tick(); n++; end
      if (n >= 2000) begin
         n_vec++; n_miss++;
         $display("FAIL wait_phase got phase=%0d, want phase=%0d within 2000 cycles", ph0, p);
      end
   endtask

   initial begin
      rstn = 1'b1; ped_req = 1'b0; flash_en = 1'b0;
      #1 rstn = 1'b0;
      #1 chk_reset();
      repeat (2) tick();
      rstn = 1'b1;
      repeat (140) tick();

      // request at cnt=15 of NS_G
      wait_enter(3'd0);
      repeat (15) tick();
      ped_req = 1'b1; tick(); ped_req = 1'b0;

      // request at cnt=2 of EW_G, held until the minimum
      wait_enter(3'd3);
      repeat (2) tick();
      ped_req = 1'b1; tick(); ped_req = 1'b0;

      // request during NS_Y, served by following EW_G
      wait_enter(3'd1);
      tick();
      ped_req = 1'b1; tick(); ped_req = 1'b0;
      wait_enter(3'd4);

      // night mode raised in EW_G
      wait_enter(3'd3);
      flash_en = 1'b1;
      wait_enter(3'd6);
      repeat (30) tick();
      flash_en = 1'b0;
      repeat (40) tick();

      repeat (800) begin
         ped_req = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 199) == 0) flash_en = ~flash_en;
         tick();
      end
      ped_req = 1'b0; flash_en = 1'b0;
      repeat (20) tick();

      // asynchronous reset in the middle of EW_Y
      wait_enter(3'd4);
      @(negedge clk);
      #1 rstn = 1'b0;
      #1 chk_reset();
      repeat (2) tick();
      rstn = 1'b1;
      repeat (140) tick();

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised two-road intersection controller that succeeds the single-signal traffic light. It sequences north-south (NS) and east-west (EW) signal heads through green, yellow and all-red phases with configurable durations. A latched pedestrian request can end a green phase early, and a night mode flashes both yellow heads. It sits directly behind the board clock/reset and drives the lamp outputs; all outputs come from registers only.

## Interface
- `CNT_W`, 8: phase counter width; every `*_T` parameter must be < 2^`CNT_W`.
- `GREEN_T`, 27: green phase lasts `GREEN_T`+1 cycles.
- `YELLOW_T`, 3: yellow phase lasts `YELLOW_T`+1 cycles.
- `ALLRED_T`, 2: all-red clearance lasts `ALLRED_T`+1 cycles.
- `MIN_GREEN_T`, 8: earliest counter value at which a pedestrian request may end green; must be ≤ `GREEN_T`.
- `FLASH_T`, 4: flash half-period is `FLASH_T`+1 cycles.
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `ped_req`  in  1  pedestrian request, level-sampled each cycle.
- `flash_en`  in  1  night-mode request, level.
- `ns_green`, `ns_yellow`, `ns_red`  out  1 each  NS head.
- `ew_green`, `ew_yellow`, `ew_red`  out  1 each  EW head.
- `ped_ack`  out  1  one-cycle pulse when a pending request is served.
- `phase`  out  3  current state encoding, for debug.

## Operation
- States and `phase` encodings: NS_G=0, NS_Y=1, AR1=2, EW_G=3, EW_Y=4, AR2=5, FLASH=6.
- `cnt` (`CNT_W` bits) increments each cycle. It clears to 0 on every state change and on every flash toggle.
- Normal sequence: NS_G→NS_Y→AR1→EW_G→EW_Y→AR2→NS_G. Each transition happens when `cnt`==T of the current phase.
- Lamp outputs:
  - NS_G: `ns_green`=1, `ew_red`=1.
  - NS_Y: `ns_yellow`=1, `ew_red`=1.
  - EW_G / EW_Y: mirror of NS_G / NS_Y.
  - AR1 / AR2: both reds=1.
  - FLASH: both yellows = `blink`, all reds and greens = 0.
  - Exactly one lamp per head is lit, except in FLASH.
- Pedestrian handling:
  - `ped_pend` sets on any cycle with `ped_req`=1, outside FLASH.
  - In NS_G or EW_G, a pending request with `cnt`≥`MIN_GREEN_T` forces the transition to yellow in that cycle.
  - `ped_pend` clears on any green→yellow transition taken while it is set. That same edge sets `ped_ack`=1 for exactly one cycle.
  - Clear wins over set: a `ped_req` in the transition cycle is absorbed into that ack.
- Flash mode:
  - Entered only at the expiry of AR1 or AR2 while `flash_en`=1; FLASH replaces the next green. Entry clears `ped_pend` and sets `blink`=1.
  - In FLASH, `blink` toggles whenever `cnt`==`FLASH_T`.
  - When `flash_en`=0 is sampled in FLASH, the next state is AR2 with `cnt`=0, so NS_G follows after clearance.
  - `flash_en` asserted during green or yellow takes effect only at the next all-red expiry.
- Requests and `flash_en` changes never alter a yellow or all-red duration.

## Timing
- Reset (async, immediate): state=AR2, `cnt`=0, `ped_pend`=0, `blink`=0, `ped_ack`=0, `phase`=5, `ns_red`=`ew_red`=1, all other lamps 0.
- After reset release, the first NS_G appears at rising edge `ALLRED_T`+1.
- Full cycle with no requests: 2·(`GREEN_T`+`YELLOW_T`+`ALLRED_T`+3) cycles; 70 with defaults.
- Early green ends after max(`MIN_GREEN_T`, request cycle)+1 cycles in green. The request-to-lamp-change latency is 1 cycle once the minimum is met.
- No combinational path from inputs to outputs; every output changes only on a `clk` edge or on reset.
- Reset asserted mid-phase returns to the reset values immediately, regardless of state, `cnt` or `blink`.
- `cnt` never exceeds the current phase's T, so wrap-around cannot occur under legal parameters.

## Test plan
- Reset then run with no stimulus for 140 cycles:
  - NS_G lasts 28, NS_Y 4, AR1 3, EW_G 28, EW_Y 4, AR2 3 cycles.
  - Period is 70.
  - `phase` sequence 0,1,2,3,4,5; `ped_ack` never pulses.
- Pulse `ped_req` at `cnt`=15 of NS_G:
  - NS_Y begins at the next edge; `ped_ack`=1 for 1 cycle; `ped_pend` clears.
- Pulse `ped_req` at `cnt`=2 of EW_G:
  - Green holds until `cnt`=8, then EW_Y follows; EW_G lasted 9 cycles.
- Pulse `ped_req` during NS_Y:
  - No change to NS_Y or AR1 durations; EW_G ends at `cnt`=8 with `ped_ack`.
- Raise `flash_en` during EW_G:
  - FLASH is entered after AR2; yellows toggle every 5 cycles starting at 1; reds are 0.
  - Dropping `flash_en` gives AR2 (3 cycles) then NS_G.
- Assert `rstn`=0 mid-EW_Y; rerun scenario 1 with `CNT_W`=4, `GREEN_T`=10, `YELLOW_T`=1:
  - Outputs take reset values immediately.
  - Period is 2·(10+1+2+3)=32.
